// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite slave memory.
//   RESP_*      : AXI response codes driven on the B and R channels.
//   strb_width  : number of byte lanes in a data word.
//   offs_width  : number of byte-offset address bits below the word index.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int offs_width(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axi_lite_mem_array.sv
// DEPTH x DATA_WIDTH synchronous RAM: byte-strobed write port plus a
// registered read port. A read and a write to the same word on the same
// edge return the old contents.
//   i_clock     : rising-edge clock
//   i_reset     : synchronous active-high, clears the read register only
//   i_wr_en     : write enable (address already known to be in range)
//   i_wr_idx    : word index to write
//   i_wr_data   : write data
//   i_wr_strb   : per-byte write enables
//   i_rd_en     : capture a new read result
//   i_rd_zero   : capture zero instead of memory (out-of-range read)
//   i_rd_idx    : word index to read
//   o_rd_data   : registered read data, held until the next i_rd_en
module axi_lite_mem_array
    import axi_lite_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 8
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_wr_en,
    input  logic [IDX_W-1:0]            i_wr_idx,
    input  logic [DATA_WIDTH-1:0]       i_wr_data,
    input  logic [DATA_WIDTH/8-1:0]     i_wr_strb,
    input  logic                        i_rd_en,
    input  logic                        i_rd_zero,
    input  logic [IDX_W-1:0]            i_rd_idx,
    output logic [DATA_WIDTH-1:0]       o_rd_data
);

    localparam int STRB_W = strb_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Byte-lane write port; storage contents survive reset on purpose.
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            for (int lane = 0; lane < STRB_W; lane++) begin
                if (i_wr_strb[lane]) begin
                    r_mem[i_wr_idx][lane*8 +: 8] <= i_wr_data[lane*8 +: 8];
                end
            end
        end
    end

    // Registered read port; non-blocking semantics give read-before-write.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rd_data <= {DATA_WIDTH{1'b0}};
        end else if (i_rd_en) begin
            r_rd_data <= i_rd_zero ? {DATA_WIDTH{1'b0}} : r_mem[i_rd_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave in front of a byte-strobed word memory.
// AW and W each have a one-entry hold and may arrive in either order; a
// write commits once both are held and no B response is outstanding.
// Reads are answered one edge after the AR handshake, one outstanding.
// Addresses outside [BASE_ADDR, BASE_ADDR + DEPTH*bytes) get DECERR.
//   clock, reset                                 : rising edge, sync active-high
//   write_address/valid/ready                    : AW channel
//   write_data/strobe/data_valid/data_ready      : W channel
//   write_response/_valid/_ready                 : B channel
//   read_address/valid/ready                     : AR channel
//   read_data/response/response_valid/_ready     : R channel
module axi_lite_slave_mem #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   write_address,
    input  logic                    write_valid,
    output logic                    write_ready,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strobe,
    input  logic                    write_data_valid,
    output logic                    write_data_ready,
    output logic [1:0]              write_response,
    output logic                    write_response_valid,
    input  logic                    write_response_ready,
    input  logic [ADDR_WIDTH-1:0]   read_address,
    input  logic                    read_valid,
    output logic                    read_ready,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic [1:0]              read_response,
    output logic                    read_response_valid,
    input  logic                    read_response_ready
);

    import axi_lite_pkg::*;

    localparam int STRB_W = strb_width(DATA_WIDTH);
    localparam int OFF_W  = offs_width(DATA_WIDTH);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One past the last mapped byte; one extra bit so the top of the
    // address space cannot wrap.
    localparam logic [ADDR_WIDTH:0] LIMIT =
        {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(DEPTH * STRB_W);

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
    endfunction

    logic                    r_aw_held;
    logic [ADDR_WIDTH-1:0]   r_aw_addr;
    logic                    r_w_held;
    logic [DATA_WIDTH-1:0]   r_w_data;
    logic [STRB_W-1:0]       r_w_strb;
    logic                    r_b_valid;
    logic [1:0]              r_b_resp;
    logic                    r_r_valid;
    logic [1:0]              r_r_resp;

    logic                    w_aw_fire;
    logic                    w_w_fire;
    logic                    w_ar_fire;
    logic                    w_commit;
    logic                    w_aw_in_range;
    logic                    w_ar_in_range;
    logic [ADDR_WIDTH-1:0]   w_aw_off;
    logic [ADDR_WIDTH-1:0]   w_ar_off;
    logic [IDX_W-1:0]        w_wr_idx;
    logic [IDX_W-1:0]        w_rd_idx;
    logic                    w_unused_off;

    assign write_ready      = !reset && !r_aw_held;
    assign write_data_ready = !reset && !r_w_held;
    assign read_ready       = !reset && (!r_r_valid || read_response_ready);

    assign w_aw_fire = write_valid && write_ready;
    assign w_w_fire  = write_data_valid && write_data_ready;
    assign w_ar_fire = read_valid && read_ready;

    // A new pair waits while B is stalled so the B payload never changes.
    assign w_commit = !reset && r_aw_held && r_w_held && !r_b_valid;

    assign w_aw_in_range = addr_in_range(r_aw_addr);
    assign w_ar_in_range = addr_in_range(read_address);

    // Word index ignores the byte-offset bits below the data width.
    assign w_aw_off = r_aw_addr - BASE_ADDR;
    assign w_ar_off = read_address - BASE_ADDR;
    assign w_wr_idx = w_aw_off[OFF_W +: IDX_W];
    assign w_rd_idx = w_ar_off[OFF_W +: IDX_W];
    assign w_unused_off = ^{w_aw_off, w_ar_off};

    // AW/W holds and B response register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_aw_held <= 1'b0;
            r_aw_addr <= {ADDR_WIDTH{1'b0}};
            r_w_held  <= 1'b0;
            r_w_data  <= {DATA_WIDTH{1'b0}};
            r_w_strb  <= {STRB_W{1'b0}};
            r_b_valid <= 1'b0;
            r_b_resp  <= RESP_OKAY;
        end else begin
            if (w_aw_fire) begin
                r_aw_held <= 1'b1;
                r_aw_addr <= write_address;
            end else if (w_commit) begin
                r_aw_held <= 1'b0;
            end

            if (w_w_fire) begin
                r_w_held <= 1'b1;
                r_w_data <= write_data;
                r_w_strb <= write_strobe;
            end else if (w_commit) begin
                r_w_held <= 1'b0;
            end

            if (w_commit) begin
                r_b_valid <= 1'b1;
                r_b_resp  <= w_aw_in_range ? RESP_OKAY : RESP_DECERR;
            end else if (write_response_ready) begin
                r_b_valid <= 1'b0;
            end
        end
    end

    // R response valid/code; data is registered inside the memory array.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_r_valid <= 1'b0;
            r_r_resp  <= RESP_OKAY;
        end else if (w_ar_fire) begin
            r_r_valid <= 1'b1;
            r_r_resp  <= w_ar_in_range ? RESP_OKAY : RESP_DECERR;
        end else if (read_response_ready) begin
            r_r_valid <= 1'b0;
        end
    end

    axi_lite_mem_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_wr_en   (w_commit && w_aw_in_range),
        .i_wr_idx  (w_wr_idx),
        .i_wr_data (r_w_data),
        .i_wr_strb (r_w_strb),
        .i_rd_en   (w_ar_fire),
        .i_rd_zero (!w_ar_in_range),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (read_data)
    );

    assign write_response_valid = r_b_valid;
    assign write_response       = r_b_resp;
    assign read_response_valid  = r_r_valid;
    assign read_response        = r_r_resp;

endmodule
